// File: rtl/handshake_tgl_rx.sv
// handshake_tgl_rx: destination-domain end of a toggle-based handshake CDC.
// The source flips req_tgl_a once per word and holds data_a stable until it
// sees the matching flip on ack_tgl. This block synchronizes the request
// level and detects its change. It captures the word into a valid/ready
// output stage and flips ack_tgl once the consumer has taken the word.
//
// Optional build macro:
//   HS_RX_ERR_EN - when defined, err latches high if a new request edge
//                  arrives while a word is still waiting for the consumer.
//                  When undefined, err is tied low and no detection logic
//                  is built.
//
// SYNC_STAGES must be in the range 2..4.
module handshake_tgl_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_tgl_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              err
);

  // One-hot encoding: the two all-zero and all-one codes are illegal and
  // steer back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_VALID = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  logic                   req_seen_q, req_seen_d;
  logic                   req_edge;
  logic                   ack_tgl_q, ack_tgl_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0]       xfer_cnt_q, xfer_cnt_d;

  // The synchronizer chain is a plain shift register. Only its last stage
  // feeds any logic, so metastability can resolve across the earlier stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_tgl_a};
  end

  // The synchronizer flops clear with the shared reset, so both sides
  // restart from level 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // A level difference between the synchronized request and the last level
  // consumed marks one pending transfer.
  assign req_edge = req_s ^ req_seen_q;

  // Next-state and datapath decisions for the IDLE/VALID handshake.
  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    ack_tgl_d   = ack_tgl_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    xfer_cnt_d  = xfer_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // data_a is held stable by the source from its toggle until our
        // ack. Sampling it on this single transition is therefore safe.
        if (req_edge) begin
          out_data_d  = data_a;
          req_seen_d  = req_s;
          out_valid_d = 1'b1;
          state_d     = ST_VALID;
        end
      end

      ST_VALID: begin
        // An edge arriving here is left pending in req_seen. It is picked
        // up on the first IDLE cycle after acceptance.
        if (out_ready) begin
          out_valid_d = 1'b0;
          ack_tgl_d   = ~ack_tgl_q;
          xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous clear drops any pending
  // word without acknowledging it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_seen_q  <= 1'b0;
      ack_tgl_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_seen_q  <= req_seen_d;
      ack_tgl_q   <= ack_tgl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign ack_tgl   = ack_tgl_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign busy      = (state_q == ST_VALID);

`ifdef HS_RX_ERR_EN
  logic err_q, err_d;

  // The flag latches when the source toggles again before its previous word
  // was acknowledged. It stays set until reset.
  always_comb begin
    err_d = err_q | (req_edge && (state_q == ST_VALID));
  end

  // Sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_tgl_rx.sv
// Testbench for handshake_tgl_rx. A source model drives toggles and words.
// The expected values come from a word queue and an accepted-transfer count.
module tb_handshake_tgl_rx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int CW = 4;
  localparam int CNT_MOD = 1 << CW;

  logic          clk;
  logic          rst_n;
  logic          req_tgl_a;
  logic [DW-1:0] data_a;
  logic          ack_tgl;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic [CW-1:0] xfer_cnt;
  logic          err;

  handshake_tgl_rx #(
    .DATA_W(DW),
    .SYNC_STAGES(SS),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_tgl_a(req_tgl_a),
    .data_a(data_a),
    .ack_tgl(ack_tgl),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .xfer_cnt(xfer_cnt),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words sent but not yet delivered, and transfers accepted.
  logic [DW-1:0] exp_q[$];
  int            model_acc = 0;
  logic          err_exp   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_ack();
    return (model_acc % 2);
  endfunction

  function automatic logic [31:0] exp_cnt();
    return (model_acc % CNT_MOD);
  endfunction

  // The source presents a word and flips its request level.
  task automatic src_toggle(input logic [DW-1:0] w);
    data_a    = w;
    req_tgl_a = ~req_tgl_a;
    exp_q.push_back(w);
  endtask

  // Wait, bounded, for out_valid. The toggle is issued right after an edge,
  // so the valid flag must appear SS+1 edges later.
  task automatic wait_valid(input string tag, input logic chk_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_valid_seen"}, out_valid, 1);
    if (chk_lat) check_eq({tag, "_latency"}, lat, SS + 1);
  endtask

  // Let a valid word sit for 'hold' cycles, then accept it.
  task automatic deliver(input string tag, input int hold);
    logic [DW-1:0] w;
    w = exp_q.pop_front();
    check_eq({tag, "_data"}, out_data, w);
    check_eq({tag, "_busy"}, busy, 1);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_data"}, out_data, w);
      check_eq({tag, "_hold_ack"}, ack_tgl, exp_ack());
    end
    out_ready = 1'b1;
    tick();
    model_acc++;
    check_eq({tag, "_acc_valid"}, out_valid, 0);
    check_eq({tag, "_acc_ack"}, ack_tgl, exp_ack());
    check_eq({tag, "_acc_cnt"}, xfer_cnt, exp_cnt());
    out_ready = 1'b0;
    $display("[TB] %s: word %02h accepted after %0d wait cycles, xfer_cnt=%0d ack=%0d",
             tag, w, hold, xfer_cnt, ack_tgl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    int gap;

`ifdef HS_RX_ERR_EN
    err_exp = 1'b1;
`endif

    // Reset values, checked before any clock edge.
    rst_n     = 1'b0;
    req_tgl_a = 1'b0;
    data_a    = '0;
    out_ready = 1'b0;
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_ack", ack_tgl, 0);
    check_eq("rst_cnt", xfer_cnt, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    $display("[TB] reset: outputs cleared");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // First transfer: consumer already ready. Valid rises at edge 3 and is
    // acknowledged at edge 4.
    out_ready = 1'b1;
    src_toggle(8'hA5);
    tick();
    tick();
    check_eq("t1_valid_early", out_valid, 0);
    tick();
    check_eq("t1_valid_edge3", out_valid, 1);
    check_eq("t1_ack_before", ack_tgl, 0);
    deliver("t1", 0);

    // Consumer stalls for 10 cycles.
    src_toggle(8'h3C);
    wait_valid("t2", 1'b1);
    deliver("t2", 10);

    // Four sequential transfers 01..04. Each toggle follows the prior ack.
    for (int i = 1; i <= 4; i++) begin
      src_toggle(DW'(i));
      wait_valid("seq", 1'b1);
      deliver("seq", i - 1);
    end
    check_eq("seq_ack_end", ack_tgl, 0);
    check_eq("seq_cnt_end", xfer_cnt, 6);

    // Protocol violation: the source toggles again while a word is pending.
    src_toggle(8'h11);
    wait_valid("viol", 1'b1);
    src_toggle(8'h22);
    repeat (4) begin
      tick();
      check_eq("viol_hold_data", out_data, 8'h11);
    end
    check_eq("viol_err", err, err_exp);
    deliver("viol_a", 0);
    tick();
    check_eq("viol_second_valid", out_valid, 1);
    deliver("viol_b", 0);
    check_eq("viol_err_sticky", err, err_exp);

    // Asynchronous reset while a word is pending.
    src_toggle(8'h77);
    wait_valid("arst", 1'b1);
    rst_n     = 1'b0;
    req_tgl_a = 1'b0;
    data_a    = '0;
    #2;
    exp_q.delete();
    model_acc = 0;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_ack", ack_tgl, 0);
    check_eq("arst_cnt", xfer_cnt, 0);
    check_eq("arst_err", err, 0);
    check_eq("arst_busy", busy, 0);
    $display("[TB] async reset: pending word dropped");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("arst_no_spurious", out_valid, 0);
    end

    // Randomized transfers. More than 2^CW of them force the counter to wrap.
    for (int i = 0; i < 20; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        data_a = DW'($urandom);
        tick();
      end
      w = DW'($urandom);
      src_toggle(w);
      wait_valid("rnd", 1'b1);
      deliver("rnd", $urandom_range(0, 4));
      if (model_acc == CNT_MOD) check_eq("cnt_wrap", xfer_cnt, 0);
    end
    check_eq("rnd_final_cnt", xfer_cnt, exp_cnt());
    check_eq("rnd_final_ack", ack_tgl, exp_ack());
    check_eq("rnd_err_clear", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_tgl_rx.md
Name: handshake_tgl_rx

Overview:
- Destination-domain end of the toggle-based handshake CDC.
- The source side toggles a request level (toggle flop, b <= a ^ b) and holds a data word stable until acknowledged.
- This block synchronizes the request toggle into clk, detects the edge, and presents the captured word on a valid/ready interface.
- Once the consumer accepts the word, the block returns an acknowledge toggle to the source domain.

Parameters:
- DATA_W, 8, width of the transferred data word.
- SYNC_STAGES, 2, flops in the request synchronizer chain; legal range 2..4.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  reset; asynchronous, active-low. Shared with the source side.
- req_tgl_a  input  1  request toggle from the source domain, asynchronous to clk. Each level change is one transfer.
- data_a  input  DATA_W  source data word. The source holds it stable from its req toggle until it sees the matching ack toggle.
- ack_tgl  output  1  acknowledge toggle back to the source domain. Registered, glitch-free.
- out_valid  output  1  captured word available.
- out_data  output  DATA_W  captured word; stable while out_valid=1.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready at a clk edge.
- busy  output  1  high in VALID state.
- xfer_cnt  output  CNT_W  count of accepted transfers.
- err  output  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset values (all registers): sync chain = 0, req_seen = 0, ack_tgl = 0, out_valid = 0, out_data = 0, xfer_cnt = 0, err = 0, state = IDLE.
- Synchronizer: req_tgl_a feeds sync[0]. Only sync[SYNC_STAGES-1] (req_s) is used by logic. No logic is placed on the chain.
- Edge detect: req_edge = req_s ^ req_seen (combinational).
- State IDLE:
  - If req_edge: out_data <= data_a, req_seen <= req_s, out_valid <= 1, go to VALID.
  - Else remain in IDLE.
- State VALID:
  - out_valid = 1 and out_data are held.
  - If out_ready: out_valid <= 0, ack_tgl <= ~ack_tgl, xfer_cnt <= xfer_cnt + 1, go to IDLE.
  - Else remain in VALID.
- data_a is sampled only on the IDLE->VALID edge. It is safe because the source holds data_a stable until the ack toggle.
- Latency:
  - req_tgl_a changes between edge 0 and edge 1 (setup met): req_s updates at edge SYNC_STAGES; out_valid rises at edge SYNC_STAGES+1.
  - Acceptance at edge n: ack_tgl toggles and out_valid falls at edge n.
- Back-to-back: a new edge is detectable from the IDLE cycle immediately after acceptance. Minimum spacing between valids is 1 idle cycle plus source round-trip.
- Edge arriving in VALID: req_seen is not updated and the edge stays pending. It is consumed on the first IDLE cycle. No data is lost, but this is a source protocol violation (see err).
- xfer_cnt wraps from 2^CNT_W-1 to 0 silently.
- busy = (state == VALID).
- Reset mid-operation: all state clears immediately (async); a pending out_valid drops with no ack. The source must be reset by the same rst_n so both toggle levels restart at 0.
- Only the two states IDLE and VALID exist. An illegal state encoding recovers to IDLE.

Optional Feature:
- Macro HS_RX_ERR_EN.
- Defined: err <= 1 when req_edge is seen while state == VALID. err is sticky until rst_n. Transfer behaviour is otherwise unchanged.
- Undefined: err is tied to 0, the detection logic is not built, and the port remains present.

Test Plan:
- Reset release, SYNC_STAGES=2, toggle req_tgl_a 0->1 with data_a=8'hA5 after edge 0, out_ready=1 -> out_valid=1 and out_data=8'hA5 at edge 3; ack_tgl 0->1 and xfer_cnt=1 at edge 4.
- out_ready held 0 for 10 cycles after valid with data 8'h3C -> out_valid and out_data=8'h3C stable all 10 cycles, ack_tgl unchanged; ready=1 -> single ack toggle, xfer_cnt +1.
- 4 sequential transfers 8'h01..8'h04, each source toggle issued only after the prior ack -> four valids in order, ack_tgl ends at 0, xfer_cnt=4.
- With HS_RX_ERR_EN: toggle req again while out_valid=1 and out_ready=0 -> err=1 and stays 1; after ready, the second transfer is delivered. Without the macro -> err stays 0.
- Assert rst_n=0 while in VALID -> out_valid, ack_tgl, xfer_cnt, err all 0 asynchronously; after release with req_tgl_a=0, no spurious valid.
- Preload xfer_cnt near wrap (CNT_W=4, 16 transfers) -> xfer_cnt wraps from 15 to 0.
